// File: rtl/c1908_query_driver_if.sv
// c1908_query_driver_if
//   Groups the key-load, query and result signals of the c1908 query driver.
//   master : the query issuer (bench or SAT-attack engine).
//   slave  : the driver itself.
//   Signals:
//     key_shift, key_sin   serial key load (MSB first)
//     key_loaded, key_drop key status / ignored-shift pulse
//     q_valid, q_ready     query handshake, q_pi carries the pattern
//     r_valid, r_ready     result handshake, r_po carries captured outputs
interface c1908_query_driver_if #(
  parameter int PI_W = 33,
  parameter int PO_W = 25
);
  logic            key_shift;
  logic            key_sin;
  logic            key_loaded;
  logic            key_drop;
  logic            q_valid;
  logic            q_ready;
  logic [PI_W-1:0] q_pi;
  logic            r_valid;
  logic            r_ready;
  logic [PO_W-1:0] r_po;

  modport master (
    output key_shift, key_sin, q_valid, q_pi, r_ready,
    input  key_loaded, key_drop, q_ready, r_valid, r_po
  );

  modport slave (
    input  key_shift, key_sin, q_valid, q_pi, r_ready,
    output key_loaded, key_drop, q_ready, r_valid, r_po
  );
endinterface

// File: rtl/c1908_query_driver.sv
// c1908_query_driver
//   Query engine around the key-locked c1908 core. A 32-bit key is shifted
//   in serially and held on core_key; each accepted query drives one pattern
//   onto core_pi, waits a settle window, captures core_po and returns it over
//   a valid/ready result handshake. All outputs are registered.
//   Ports:
//     clk       rising-edge clock
//     rst_n     synchronous active-low reset
//     bus       key/query/result signals (slave side)
//     q_count   completed queries, wraps
//     core_key  to locked core keyinput0..31
//     core_pi   to locked core N1..N104
//     core_po   from locked core N2753..N2899 (combinational)
module c1908_query_driver #(
  parameter int KEY_W  = 32,
  parameter int PI_W   = 33,
  parameter int PO_W   = 25,
  parameter int SETTLE = 2,   // legal range 1..15
  parameter int QCNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  c1908_query_driver_if.slave   bus,
  output logic [QCNT_W-1:0]     q_count,
  output logic [KEY_W-1:0]      core_key,
  output logic [PI_W-1:0]       core_pi,
  input  logic [PO_W-1:0]       core_po
);

  localparam int BCNT_W = $clog2(KEY_W);
  localparam int SCNT_W = 4;

  typedef enum logic [1:0] {
    ST_NOKEY,
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t              state_q,      state_d;
  logic [BCNT_W-1:0]   bcnt_q,       bcnt_d;
  logic [SCNT_W-1:0]   scnt_q,       scnt_d;
  logic [KEY_W-1:0]    shadow_q,     shadow_d;
  logic [KEY_W-1:0]    core_key_q,   core_key_d;
  logic [PI_W-1:0]     core_pi_q,    core_pi_d;
  logic [PO_W-1:0]     r_po_q,       r_po_d;
  logic                r_valid_q,    r_valid_d;
  logic                q_ready_q,    q_ready_d;
  logic                key_loaded_q, key_loaded_d;
  logic                key_drop_q,   key_drop_d;
  logic [QCNT_W-1:0]   q_count_q,    q_count_d;
  logic                accept;

  // q_ready_q already implies IDLE with no partial key load.
  assign accept = bus.q_valid && q_ready_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers latches.
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    scnt_d       = scnt_q;
    shadow_d     = shadow_q;
    core_key_d   = core_key_q;
    core_pi_d    = core_pi_q;
    r_po_d       = r_po_q;
    r_valid_d    = r_valid_q;
    key_loaded_d = key_loaded_q;
    key_drop_d   = 1'b0;
    q_count_d    = q_count_q;

    unique case (state_q)
      ST_NOKEY, ST_IDLE: begin
        if (accept) begin
          // A query wins over a simultaneous key bit; the bit is reported dropped.
          core_pi_d  = bus.q_pi;
          // Counting SETTLE..0 puts the capture SETTLE+1 edges after the accept edge.
          scnt_d     = SCNT_W'(SETTLE);
          state_d    = ST_SETTLE;
          key_drop_d = bus.key_shift;
        end else if (bus.key_shift) begin
          shadow_d = {shadow_q[KEY_W-2:0], bus.key_sin};
          if (bcnt_q == BCNT_W'(KEY_W - 1)) begin
            core_key_d   = shadow_d;
            bcnt_d       = '0;
            key_loaded_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        key_drop_d = bus.key_shift;
        if (scnt_q == '0) begin
          r_po_d    = core_po;
          r_valid_d = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end

      ST_HOLD: begin
        key_drop_d = bus.key_shift;
        if (bus.r_ready) begin
          r_valid_d = 1'b0;
          q_count_d = q_count_q + 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_NOKEY;
    endcase

    // Registered ready: reflects the state being entered, so it never turns
    // around in the same cycle as the result handshake.
    q_ready_d = (state_d == ST_IDLE) && (bcnt_d == '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values; reset is synchronous, checked inside the edge.
    if (!rst_n) begin
      state_q      <= ST_NOKEY;
      bcnt_q       <= '0;
      scnt_q       <= '0;
      shadow_q     <= '0;
      core_key_q   <= '0;
      core_pi_q    <= '0;
      r_po_q       <= '0;
      r_valid_q    <= 1'b0;
      q_ready_q    <= 1'b0;
      key_loaded_q <= 1'b0;
      key_drop_q   <= 1'b0;
      q_count_q    <= '0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      scnt_q       <= scnt_d;
      shadow_q     <= shadow_d;
      core_key_q   <= core_key_d;
      core_pi_q    <= core_pi_d;
      r_po_q       <= r_po_d;
      r_valid_q    <= r_valid_d;
      q_ready_q    <= q_ready_d;
      key_loaded_q <= key_loaded_d;
      key_drop_q   <= key_drop_d;
      q_count_q    <= q_count_d;
    end
  end

  assign bus.key_loaded = key_loaded_q;
  assign bus.key_drop   = key_drop_q;
  assign bus.q_ready    = q_ready_q;
  assign bus.r_valid    = r_valid_q;
  assign bus.r_po       = r_po_q;
  assign q_count        = q_count_q;
  assign core_key       = core_key_q;
  assign core_pi        = core_pi_q;

endmodule

// File: tb/tb_c1908_query_driver.sv
// tb_c1908_query_driver
//   Directed bench for c1908_query_driver. The locked core is modelled as
//   core_po = core_pi[24:0] ^ core_key[24:0]. The query counter is built
//   8 bits wide so its wrap is reachable in a short run.
module tb_c1908_query_driver;
  localparam int QCNT_W = 8;
  localparam logic [31:0] KEY_A = 32'hA5C3_0F96;
  localparam logic [31:0] KEY_B = 32'h3C96_E01B;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [QCNT_W-1:0] q_count;
  logic [31:0]       core_key;
  logic [32:0]       core_pi;
  logic [24:0]       core_po;

  int n_vec = 0;
  int n_bad = 0;

  c1908_query_driver_if #(.PI_W(33), .PO_W(25)) bus ();

  c1908_query_driver #(.QCNT_W(QCNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .q_count  (q_count),
    .core_key (core_key),
    .core_pi  (core_pi),
    .core_po  (core_po)
  );

  // Locked-core stand-in.
  assign core_po = core_pi[24:0] ^ core_key[24:0];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] k, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus.key_shift = 1'b1;
      bus.key_sin   = k[i];
      tick();
    end
    bus.key_shift = 1'b0;
  endtask

  // Fixed-timing query with immediate result acceptance (5 edges).
  task automatic run_query(input logic [32:0] pi);
    bus.q_valid = 1'b1;
    bus.q_pi    = pi;
    tick();
    bus.q_valid = 1'b0;
    repeat (3) tick();
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
  endtask

  function automatic logic [24:0] model_po(input logic [32:0] pi, input logic [31:0] k);
    return pi[24:0] ^ k[24:0];
  endfunction

  initial begin
    logic [32:0] pi3;
    rst_n         = 1'b0;
    bus.key_shift = 1'b0;
    bus.key_sin   = 1'b0;
    bus.q_valid   = 1'b0;
    bus.q_pi      = '0;
    bus.r_ready   = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_key_loaded", bus.key_loaded, 0);
    check("rst_q_ready",    bus.q_ready,    0);
    check("rst_r_valid",    bus.r_valid,    0);
    check("rst_key_drop",   bus.key_drop,   0);
    check("rst_core_key",   core_key,       0);
    check("rst_core_pi",    core_pi,        0);
    check("rst_r_po",       bus.r_po,       0);
    check("rst_q_count",    q_count,        0);
    rst_n = 1'b1;

    // Query with no key is ignored
    bus.q_valid = 1'b1;
    bus.q_pi    = 33'h1_2345_6789;
    tick();
    bus.q_valid = 1'b0;
    check("nokey_q_ready", bus.q_ready, 0);
    check("nokey_core_pi", core_pi,     0);

    // 1. Serial key load
    shift_bits(KEY_A, 31, 1);
    check("key31_core_key",   core_key,       0);
    check("key31_key_loaded", bus.key_loaded, 0);
    check("key31_q_ready",    bus.q_ready,    0);
    shift_bits(KEY_A, 0, 0);
    check("key32_core_key",   core_key,       KEY_A);
    check("key32_key_loaded", bus.key_loaded, 1);
    check("key32_q_ready",    bus.q_ready,    1);

    // 2. Query: PI[24:0]=0x0000001, key[24:0]=0x1C30F96 -> 0x1C30F97
    bus.q_valid = 1'b1;
    bus.q_pi    = 33'h1_0000_0001;
    tick();
    bus.q_valid = 1'b0;
    check("q1_q_ready_drop", bus.q_ready, 0);
    check("q1_core_pi",      core_pi,     33'h1_0000_0001);
    tick();
    check("q1_r_valid_a1", bus.r_valid, 0);
    tick();
    check("q1_r_valid_a2", bus.r_valid, 0);
    tick();
    check("q1_r_valid_a3", bus.r_valid, 1);
    check("q1_r_po",       bus.r_po,    25'h1C3_0F97);
    // Hold with r_ready low; a new pattern offered meanwhile must not latch
    bus.q_valid = 1'b1;
    bus.q_pi    = 33'h0_FFFF_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("q1_hold_r_valid", bus.r_valid, 1);
      check("q1_hold_r_po",    bus.r_po,    25'h1C3_0F97);
    end
    check("q1_hold_core_pi", core_pi,     33'h1_0000_0001);
    check("q1_hold_q_ready", bus.q_ready, 0);
    bus.q_valid = 1'b0;
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    check("q1_done_r_valid", bus.r_valid, 0);
    check("q1_done_q_count", q_count,     1);
    check("q1_done_q_ready", bus.q_ready, 1);

    // 3. key_shift while busy is dropped
    bus.q_valid = 1'b1;
    bus.q_pi    = 33'h0_1234_5678;
    tick();
    bus.q_valid   = 1'b0;
    bus.key_shift = 1'b1;
    bus.key_sin   = 1'b1;
    tick();
    check("drop_settle1", bus.key_drop, 1);
    tick();
    check("drop_settle2", bus.key_drop, 1);
    tick();
    check("drop_settle3", bus.key_drop, 1);
    check("drop_r_valid", bus.r_valid,  1);
    tick();
    check("drop_hold",    bus.key_drop, 1);
    bus.key_shift = 1'b0;
    tick();
    check("drop_end",      bus.key_drop, 0);
    check("drop_core_key", core_key,     KEY_A);
    check("drop_r_po",     bus.r_po,     model_po(33'h0_1234_5678, KEY_A));
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    check("drop_q_ready", bus.q_ready, 1);
    check("drop_q_count", q_count,     2);

    // 4. Partial key blocks queries
    pi3 = 33'h1_ABCD_0123;
    shift_bits(KEY_B, 31, 16);
    bus.q_valid = 1'b1;
    bus.q_pi    = pi3;
    repeat (3) tick();
    check("part_q_ready",    bus.q_ready, 0);
    check("part_core_pi",    core_pi,     33'h0_1234_5678);
    check("part_core_key",   core_key,    KEY_A);
    shift_bits(KEY_B, 15, 0);
    check("part_full_key",   core_key,    KEY_B);
    check("part_full_ready", bus.q_ready, 1);
    tick();
    bus.q_valid = 1'b0;
    check("part_accept_pi",    core_pi,     pi3);
    check("part_accept_ready", bus.q_ready, 0);
    repeat (3) tick();
    check("part_r_valid", bus.r_valid, 1);
    check("part_r_po",    bus.r_po,    model_po(pi3, KEY_B));
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    check("part_q_count", q_count, 3);

    // 5. Query counter wrap
    for (int n = 3; n < 255; n++) run_query(33'(n));
    check("wrap_q_count_max", q_count, 255);
    run_query(33'h0_0000_00FF);
    check("wrap_q_count_zero", q_count, 0);

    // 6. Reset during HOLD
    bus.q_valid = 1'b1;
    bus.q_pi    = 33'h0_0F0F_0F0F;
    tick();
    bus.q_valid = 1'b0;
    repeat (3) tick();
    check("rst6_pre_r_valid", bus.r_valid, 1);
    rst_n = 1'b0;
    tick();
    check("rst6_r_valid",    bus.r_valid,    0);
    check("rst6_key_loaded", bus.key_loaded, 0);
    check("rst6_core_key",   core_key,       0);
    check("rst6_q_ready",    bus.q_ready,    0);
    check("rst6_r_po",       bus.r_po,       0);
    rst_n = 1'b1;
    tick();
    check("rst6_after_q_ready", bus.q_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule
